// File: rtl/pipelined_shifter.sv
// rtl/pipelined_shifter.sv - pipelined four-mode barrel shifter with valid/ready handshake
// One mux level per registered stage; the last stage register drives the outputs directly.

module pipelined_shifter #(
    parameter  int Nbits  = 8,
    localparam int LEVELS = $clog2(Nbits)
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              IN_VALID,
    output logic              IN_READY,
    input  logic [Nbits-1:0]  A,
    input  logic [LEVELS-1:0] SHAMT,
    input  logic [1:0]        MODE,
    output logic              OUT_VALID,
    input  logic              OUT_READY,
    output logic [Nbits-1:0]  OUT,
    output logic              CARRY,
    output logic              OVERFLOW
);

    localparam logic [1:0] MODE_LSR = 2'b00;
    localparam logic [1:0] MODE_ASR = 2'b01;
    localparam logic [1:0] MODE_LSL = 2'b10;
    localparam logic [1:0] MODE_ROR = 2'b11;

    // Single stall enable: the whole pipe freezes only when the output is held.
    logic en;
    assign en       = !OUT_VALID || OUT_READY;
    assign IN_READY = en;

    for (genvar k = 0; k < LEVELS; k++) begin : g_stage
        localparam int AMT = 1 << k;
        localparam int SW  = LEVELS - k;

        logic [Nbits-1:0] src_data;
        logic [SW-1:0]    src_shamt;
        logic [1:0]       src_mode;
        logic             src_msb;
        logic             src_carry;
        logic             src_valid;

        logic [Nbits-1:0] shift_data;
        logic             shift_carry;

        logic [Nbits-1:0] data_d, data_q;
        logic             msb_d, msb_q;
        logic             carry_d, carry_q;
        logic             valid_d, valid_q;

        if (k == 0) begin : g_src
            assign src_data  = A;
            assign src_shamt = SHAMT;
            assign src_mode  = MODE;
            assign src_msb   = A[Nbits-1];
            assign src_carry = 1'b0;
            assign src_valid = IN_VALID;
        end else begin : g_src
            assign src_data  = g_stage[k-1].data_q;
            assign src_shamt = g_stage[k-1].g_fwd.shamt_q;
            assign src_mode  = g_stage[k-1].g_fwd.mode_q;
            assign src_msb   = g_stage[k-1].msb_q;
            assign src_carry = g_stage[k-1].carry_q;
            assign src_valid = g_stage[k-1].valid_q;
        end

        // src_shamt[0] is always this level's bit; consumed bits are dropped as we go.
        always_comb begin
            shift_data  = src_data;
            shift_carry = src_carry;
            if (src_shamt[0]) begin
                case (src_mode)
                    MODE_LSR: begin
                        shift_data  = src_data >> AMT;
                        shift_carry = src_data[AMT-1];
                    end
                    MODE_ASR: begin
                        shift_data  = (src_data >> AMT) | ({Nbits{src_msb}} << (Nbits - AMT));
                        shift_carry = src_data[AMT-1];
                    end
                    MODE_LSL: begin
                        shift_data  = src_data << AMT;
                        shift_carry = src_data[Nbits-AMT];
                    end
                    MODE_ROR: begin
                        shift_data  = (src_data >> AMT) | (src_data << (Nbits - AMT));
                        shift_carry = src_data[AMT-1];
                    end
                endcase
            end
        end

        always_comb begin
            data_d  = en ? shift_data  : data_q;
            msb_d   = en ? src_msb     : msb_q;
            carry_d = en ? shift_carry : carry_q;
            valid_d = en ? src_valid   : valid_q;
        end

        always_ff @(posedge CLK or negedge RST_N) begin
            if (!RST_N) begin
                data_q  <= '0;
                msb_q   <= 1'b0;
                carry_q <= 1'b0;
                valid_q <= 1'b0;
            end else begin
                data_q  <= data_d;
                msb_q   <= msb_d;
                carry_q <= carry_d;
                valid_q <= valid_d;
            end
        end

        if (k < LEVELS - 1) begin : g_fwd
            logic [SW-2:0] shamt_d, shamt_q;
            logic [1:0]    mode_d, mode_q;

            always_comb begin
                shamt_d = en ? src_shamt[SW-1:1] : shamt_q;
                mode_d  = en ? src_mode          : mode_q;
            end

            always_ff @(posedge CLK or negedge RST_N) begin
                if (!RST_N) begin
                    shamt_q <= '0;
                    mode_q  <= '0;
                end else begin
                    shamt_q <= shamt_d;
                    mode_q  <= mode_d;
                end
            end
        end
    end

    assign OUT_VALID = g_stage[LEVELS-1].valid_q;
    assign OUT       = g_stage[LEVELS-1].data_q;
    assign CARRY     = g_stage[LEVELS-1].carry_q;
    assign OVERFLOW  = g_stage[LEVELS-1].msb_q ^ g_stage[LEVELS-1].data_q[Nbits-1];

endmodule
